// File: rtl/jump_controller_if.sv
// Signal bundle between the jump controller and the rest of the game:
// screen/button/platform inputs in, character commands and status out.
interface jump_controller_if;
    logic        game_en;
    logic        btn_left;
    logic        btn_right;
    logic        next_dir;
    logic        landed;
    logic        one_ms_tick;
    logic        jump_left;
    logic        jump_right;
    logic        jump_fail;
    logic        advance;
    logic [13:0] score;
    logic        game_over;
    logic        busy;

    // Controller side: consumes game inputs, drives commands and status.
    modport master (
        input  game_en, btn_left, btn_right, next_dir, landed,
        output one_ms_tick, jump_left, jump_right, jump_fail, advance,
               score, game_over, busy
    );

    // Environment side: drives game inputs, observes commands and status.
    modport slave (
        output game_en, btn_left, btn_right, next_dir, landed,
        input  one_ms_tick, jump_left, jump_right, jump_fail, advance,
               score, game_over, busy
    );
endinterface

// File: rtl/jump_controller.sv
// Jump controller: free-running 1 ms strobe plus the game FSM that turns
// button presses into jump/fail commands, times out missing landings,
// runs the fall sequence and keeps a saturating score.
module jump_controller #(
    parameter int TICKS_PER_MS    = 40000,
    parameter int JUMP_TIMEOUT_MS = 200,
    parameter int FALL_MS         = 500
) (
    input  logic              clk,
    input  logic              rst,
    jump_controller_if.master bus
);

    localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);

    // ms_cnt saturates at 1023, so limits above that are clamped to stay reachable.
    localparam int JT_LIM   = (JUMP_TIMEOUT_MS > 1023) ? 1023 : JUMP_TIMEOUT_MS;
    localparam int FALL_LIM = (FALL_MS > 1023) ? 1023 : FALL_MS;
    localparam logic [9:0]  JUMP_LIM  = 10'(JT_LIM);
    localparam logic [9:0]  FALL_END  = 10'(FALL_LIM);
    localparam logic [9:0]  MS_MAX    = 10'h3FF;
    localparam logic [13:0] SCORE_MAX = 14'd9999;

    typedef enum logic [2:0] {
        S_WAIT,
        S_READY,
        S_JUMP,
        S_FALL,
        S_OVER
    } state_t;

    function automatic logic [9:0] ms_sat_inc(input logic [9:0] v);
        return (v == MS_MAX) ? v : v + 10'd1;
    endfunction

    function automatic logic [13:0] score_sat_inc(input logic [13:0] v);
        return (v >= SCORE_MAX) ? SCORE_MAX : v + 14'd1;
    endfunction

    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_cnt_nxt;
    logic              tick_r;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  ms_cnt;
    logic [9:0]  ms_nxt;
    logic [9:0]  ms_inc;
    logic [13:0] score_r;
    logic [13:0] score_nxt;
    logic        jl_r, jr_r, jf_r, adv_r, over_r, busy_r;
    logic        jl_nxt, jr_nxt, jf_nxt, adv_nxt, over_nxt, busy_nxt;
    logic        btn_one;
    logic        btn_match;

    // Next value of the ms prescaler: wraps after TICKS_PER_MS-1.
    always_comb begin
        tick_cnt_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
    end

    // Prescaler and registered strobe, high exactly while the count is at its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            tick_r   <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt_nxt;
            tick_r   <= (tick_cnt_nxt == TICK_LAST);
        end
    end

    // Game FSM next-state and next-output decode; game_en low always wins.
    always_comb begin
        state_nxt = state;
        ms_nxt    = ms_cnt;
        score_nxt = score_r;
        jl_nxt    = 1'b0;
        jr_nxt    = 1'b0;
        jf_nxt    = 1'b0;
        adv_nxt   = 1'b0;
        btn_one   = bus.btn_left ^ bus.btn_right;
        btn_match = (bus.btn_right & bus.next_dir) | (bus.btn_left & ~bus.next_dir);
        ms_inc    = ms_sat_inc(ms_cnt);

        case (state)
            S_WAIT: begin
                if (bus.game_en) begin
                    score_nxt = '0;
                    ms_nxt    = '0;
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (!bus.game_en) begin
                    state_nxt = S_WAIT;
                end else if (btn_one) begin
                    ms_nxt = '0;
                    if (btn_match) begin
                        jl_nxt    = bus.btn_left;
                        jr_nxt    = bus.btn_right;
                        state_nxt = S_JUMP;
                    end else begin
                        jf_nxt    = 1'b1;
                        state_nxt = S_FALL;
                    end
                end
            end
            S_JUMP: begin
                if (!bus.game_en) begin
                    state_nxt = S_WAIT;
                end else if (bus.landed) begin
                    // A landing in the same cycle as the timeout tick still counts.
                    score_nxt = score_sat_inc(score_r);
                    adv_nxt   = 1'b1;
                    state_nxt = S_READY;
                end else if (tick_r) begin
                    if (ms_inc >= JUMP_LIM) begin
                        jf_nxt    = 1'b1;
                        ms_nxt    = '0;
                        state_nxt = S_FALL;
                    end else begin
                        ms_nxt = ms_inc;
                    end
                end
            end
            S_FALL: begin
                if (!bus.game_en) begin
                    state_nxt = S_WAIT;
                end else if (tick_r) begin
                    ms_nxt = ms_inc;
                    if (ms_inc >= FALL_END) begin
                        state_nxt = S_OVER;
                    end
                end
            end
            S_OVER: begin
                if (!bus.game_en) begin
                    state_nxt = S_WAIT;
                end
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase

        over_nxt = (state_nxt == S_OVER);
        busy_nxt = (state_nxt == S_JUMP) || (state_nxt == S_FALL);
    end

    // FSM state, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_WAIT;
            ms_cnt  <= '0;
            score_r <= '0;
            jl_r    <= 1'b0;
            jr_r    <= 1'b0;
            jf_r    <= 1'b0;
            adv_r   <= 1'b0;
            over_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ms_cnt  <= ms_nxt;
            score_r <= score_nxt;
            jl_r    <= jl_nxt;
            jr_r    <= jr_nxt;
            jf_r    <= jf_nxt;
            adv_r   <= adv_nxt;
            over_r  <= over_nxt;
            busy_r  <= busy_nxt;
        end
    end

    assign bus.one_ms_tick = tick_r;
    assign bus.jump_left   = jl_r;
    assign bus.jump_right  = jr_r;
    assign bus.jump_fail   = jf_r;
    assign bus.advance     = adv_r;
    assign bus.score       = score_r;
    assign bus.game_over   = over_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_jump_controller.sv
// Self-checking bench for jump_controller with a rule-level game model.
module tb_jump_controller;

    localparam int TPM = 4;
    localparam int JTO = 5;
    localparam int FMS = 3;

    localparam int M_WAIT  = 0;
    localparam int M_READY = 1;
    localparam int M_JUMP  = 2;
    localparam int M_FALL  = 3;
    localparam int M_OVER  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    jump_controller_if jif ();

    jump_controller #(
        .TICKS_PER_MS   (TPM),
        .JUMP_TIMEOUT_MS(JTO),
        .FALL_MS        (FMS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(jif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: game rules in terms of elapsed cycles, ms and score.
    int   m_t;
    int   m_mode;
    int   m_ms;
    int   m_score;
    logic e_tick, e_jl, e_jr, e_jf, e_adv;

    function automatic void model_reset();
        m_t     = 0;
        m_mode  = M_WAIT;
        m_ms    = 0;
        m_score = 0;
        e_tick  = 1'b0;
        e_jl    = 1'b0;
        e_jr    = 1'b0;
        e_jf    = 1'b0;
        e_adv   = 1'b0;
    endfunction

    function automatic void model_edge();
        bit tick_seen;
        bit one_btn;
        bit match;
        if (rst) begin
            model_reset();
            return;
        end
        tick_seen = (m_t > 0) && ((m_t % TPM) == TPM - 1);
        m_t++;
        e_tick = ((m_t % TPM) == TPM - 1);
        e_jl = 1'b0;
        e_jr = 1'b0;
        e_jf = 1'b0;
        e_adv = 1'b0;
        one_btn = (jif.btn_left != jif.btn_right);
        match = jif.next_dir ? jif.btn_right : jif.btn_left;
        if (!jif.game_en) begin
            m_mode = M_WAIT;
        end else begin
            case (m_mode)
                M_WAIT: begin
                    m_score = 0;
                    m_mode  = M_READY;
                end
                M_READY: begin
                    if (one_btn) begin
                        m_ms = 0;
                        if (match) begin
                            e_jl = jif.btn_left;
                            e_jr = jif.btn_right;
                            m_mode = M_JUMP;
                        end else begin
                            e_jf = 1'b1;
                            m_mode = M_FALL;
                        end
                    end
                end
                M_JUMP: begin
                    if (jif.landed) begin
                        m_score = (m_score >= 9999) ? 9999 : m_score + 1;
                        e_adv = 1'b1;
                        m_mode = M_READY;
                    end else if (tick_seen) begin
                        m_ms++;
                        if (m_ms >= JTO) begin
                            e_jf = 1'b1;
                            m_ms = 0;
                            m_mode = M_FALL;
                        end
                    end
                end
                M_FALL: begin
                    if (tick_seen) begin
                        m_ms++;
                        if (m_ms >= FMS) m_mode = M_OVER;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [20:0] exp_vec();
        logic go, bz;
        go = (m_mode == M_OVER);
        bz = (m_mode == M_JUMP) || (m_mode == M_FALL);
        return {e_tick, e_jl, e_jr, e_jf, e_adv, go, bz, 14'(m_score)};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {jif.one_ms_tick, jif.jump_left, jif.jump_right, jif.jump_fail,
                jif.advance, jif.game_over, jif.busy, jif.score};
    endfunction

    // One clock: model advances on the edge, bench resumes on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        jif.btn_left  = 1'b0;
        jif.btn_right = 1'b0;
        jif.landed    = 1'b0;
    endtask

    task automatic to_ready();
        clear_inputs();
        jif.game_en = 1'b0;
        step();
        jif.game_en = 1'b1;
        step();
    endtask

    task automatic press(input bit dir_right);
        jif.btn_right = dir_right;
        jif.btn_left  = !dir_right;
        step();
        jif.btn_right = 1'b0;
        jif.btn_left  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        jif.game_en  = 1'b0;
        jif.next_dir = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        checks++;
        if (dut_vec() !== 21'd0) begin
            errors++;
            $display("FAIL reset_async: got %h required 0", dut_vec());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec() !== 21'd0) begin
            errors++;
            $display("FAIL reset_held: got %h required 0", dut_vec());
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_free_run();
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if (jif.one_ms_tick !== ((c == 3) || (c == 7) || (c == 11))) begin
                errors++;
                $display("FAIL free_run_tick c=%0d: got %b", c, jif.one_ms_tick);
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL free_run_vec c=%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_good_jump();
        to_ready();
        jif.next_dir = 1'b1;
        press(1'b1);
        checks++;
        if ({jif.jump_right, jif.jump_left, jif.jump_fail, jif.busy} !== 4'b1001) begin
            errors++;
            $display("FAIL good_jump_cmd: got jr/jl/jf/busy=%b%b%b%b required 1001",
                     jif.jump_right, jif.jump_left, jif.jump_fail, jif.busy);
        end
        for (int c = 1; c < 10; c++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL good_jump_wait c=%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
        jif.landed = 1'b1;
        step();
        jif.landed = 1'b0;
        checks++;
        if ({jif.advance, jif.score, jif.busy} !== {1'b1, 14'd1, 1'b0}) begin
            errors++;
            $display("FAIL good_jump_land: got adv=%b score=%0d busy=%b required 1/1/0",
                     jif.advance, jif.score, jif.busy);
        end
        step();
        checks++;
        if ({jif.advance, jif.busy, jif.game_over, jif.score} !== {3'b000, 14'd1}) begin
            errors++;
            $display("FAIL good_jump_ready: got adv=%b busy=%b over=%b score=%0d",
                     jif.advance, jif.busy, jif.game_over, jif.score);
        end
    endtask

    task automatic test_wrong_button();
        int ticks;
        bit seen;
        to_ready();
        jif.next_dir = 1'b0;
        press(1'b1);
        checks++;
        if ({jif.jump_fail, jif.jump_left, jif.jump_right, jif.busy} !== 4'b1001) begin
            errors++;
            $display("FAIL wrong_btn_cmd: got jf/jl/jr/busy=%b%b%b%b required 1001",
                     jif.jump_fail, jif.jump_left, jif.jump_right, jif.busy);
        end
        ticks = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (jif.one_ms_tick) ticks++;
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrong_btn_fall c=%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
            seen = jif.game_over;
        end
        checks++;
        if (!seen || ticks != FMS) begin
            errors++;
            $display("FAIL wrong_btn_over: got over=%b after %0d ticks required 1 after %0d",
                     seen, ticks, FMS);
        end
        jif.game_en = 1'b0;
        step();
        checks++;
        if ({jif.game_over, jif.busy} !== 2'b00 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL wrong_btn_exit: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_timeout();
        int ticks;
        bit seen;
        int score0;
        to_ready();
        jif.next_dir = 1'b0;
        press(1'b0);
        ticks = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (jif.one_ms_tick) ticks++;
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL timeout_run c=%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
            seen = jif.jump_fail;
        end
        checks++;
        if (!seen || ticks != JTO) begin
            errors++;
            $display("FAIL timeout_fail: got jf=%b after %0d ticks required 1 after %0d",
                     seen, ticks, JTO);
        end
        // Landed arriving with the timeout tick must win.
        to_ready();
        jif.next_dir = 1'b1;
        press(1'b1);
        score0 = jif.score;
        ticks = 0;
        for (int c = 0; c < 40 && ticks < JTO; c++) begin
            if (jif.one_ms_tick) ticks++;
            if (ticks == JTO) jif.landed = 1'b1;
            step();
            jif.landed = 1'b0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL collide_run c=%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({jif.advance, jif.jump_fail} !== 2'b10 || jif.score !== 14'(score0 + 1)) begin
            errors++;
            $display("FAIL collide_land: got adv=%b jf=%b score=%0d required 1/0/%0d",
                     jif.advance, jif.jump_fail, jif.score, score0 + 1);
        end
        step();
        checks++;
        if ({jif.jump_fail, jif.busy} !== 2'b00) begin
            errors++;
            $display("FAIL collide_after: got jf=%b busy=%b required 0/0", jif.jump_fail, jif.busy);
        end
    endtask

    task automatic test_collisions();
        bit dir;
        to_ready();
        jif.next_dir = 1'b1;
        jif.btn_left = 1'b1;
        jif.btn_right = 1'b1;
        step();
        clear_inputs();
        checks++;
        if ({jif.jump_left, jif.jump_right, jif.jump_fail, jif.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL both_btn: got jl/jr/jf/busy=%b%b%b%b required 0000",
                     jif.jump_left, jif.jump_right, jif.jump_fail, jif.busy);
        end
        // Climb to the score ceiling with back-to-back quick jumps.
        for (int n = 0; n < 10000 && m_score < 9999; n++) begin
            dir = 1'($urandom_range(0, 1));
            jif.next_dir = dir;
            press(dir);
            jif.landed = 1'b1;
            step();
            jif.landed = 1'b0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL climb n=%0d: got %h required %h", n, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (jif.score !== 14'd9999) begin
            errors++;
            $display("FAIL climb_top: got %0d required 9999", jif.score);
        end
        jif.next_dir = 1'b0;
        press(1'b0);
        jif.landed = 1'b1;
        step();
        jif.landed = 1'b0;
        checks++;
        if ({jif.advance, jif.score} !== {1'b1, 14'd9999}) begin
            errors++;
            $display("FAIL score_sat: got adv=%b score=%0d required 1/9999", jif.advance, jif.score);
        end
    endtask

    task automatic test_abort();
        to_ready();
        jif.next_dir = 1'b1;
        press(1'b1);
        step();
        checks++;
        if (jif.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got busy=%b required 1", jif.busy);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 21'd0) begin
            errors++;
            $display("FAIL abort_rst: got %h required 0", dut_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL abort_after c=%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
        to_ready();
        jif.next_dir = 1'b0;
        press(1'b0);
        step();
        jif.game_en = 1'b0;
        jif.landed = 1'b1;
        step();
        jif.landed = 1'b0;
        checks++;
        if ({jif.advance, jif.busy, jif.jump_fail} !== 3'b000 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL abort_game_en: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        to_ready();
        for (int c = 0; c < 3000; c++) begin
            jif.game_en   = ($urandom_range(0, 99) < 98);
            jif.next_dir  = 1'($urandom_range(0, 1));
            jif.btn_left  = ($urandom_range(0, 99) < 8);
            jif.btn_right = ($urandom_range(0, 99) < 8);
            jif.landed    = ($urandom_range(0, 99) < 6);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random c=%0d: got %h required %h", c, dut_vec(), exp_vec());
            end
        end
        clear_inputs();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_good_jump();
        test_wrong_button();
        test_timeout();
        test_collisions();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
